// File: rtl/instruction_decoder.sv
// Fetch/decode stage: 16x8 program memory, instruction register,
// three-cycle FETCH/DECODE/EXEC sequencer and carry flag.
module instruction_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] pc,
    input  logic       carry_in,
    input  logic       run,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [3:0] imm,
    output logic [1:0] sel,
    output logic       ld_a,
    output logic       ld_b,
    output logic       ld_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       carry_flag,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        DECODE = 2'b01,
        EXEC   = 2'b10
    } state_t;

    state_t     cur;
    state_t     nxt;
    logic [7:0] mem [16];
    logic [7:0] ir;

    logic [1:0] d_sel;
    logic       d_ld_a;
    logic       d_ld_b;
    logic       d_ld_out;
    logic       d_pc_inc;
    logic       d_pc_load;
    logic       is_add;

    assign state  = cur;
    assign is_add = (ir[7:4] == 4'b0000) || (ir[7:4] == 4'b0101);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= FETCH;
        else     cur <= nxt;
    end

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:   nxt = run ? DECODE : FETCH;
            DECODE:  nxt = EXEC;
            EXEC:    nxt = FETCH;
            default: nxt = FETCH;
        endcase
    end

    // Unlisted opcodes fall through as NOP: sel=11, advance only.
    always_comb begin
        d_sel     = 2'b11;
        d_ld_a    = 1'b0;
        d_ld_b    = 1'b0;
        d_ld_out  = 1'b0;
        d_pc_inc  = 1'b1;
        d_pc_load = 1'b0;
        case (ir[7:4])
            4'b0000: begin d_sel = 2'b00; d_ld_a = 1'b1; end
            4'b0101: begin d_sel = 2'b01; d_ld_b = 1'b1; end
            4'b0011: begin d_sel = 2'b11; d_ld_a = 1'b1; end
            4'b0111: begin d_sel = 2'b11; d_ld_b = 1'b1; end
            4'b0001: begin d_sel = 2'b01; d_ld_a = 1'b1; end
            4'b0100: begin d_sel = 2'b00; d_ld_b = 1'b1; end
            4'b0010: begin d_sel = 2'b10; d_ld_a = 1'b1; end
            4'b0110: begin d_sel = 2'b10; d_ld_b = 1'b1; end
            4'b1001: begin d_sel = 2'b01; d_ld_out = 1'b1; end
            4'b1011: begin d_sel = 2'b11; d_ld_out = 1'b1; end
            4'b1111: begin
                d_pc_load = 1'b1;
                d_pc_inc  = 1'b0;
            end
            4'b1110: begin
                d_pc_load = ~carry_flag;
                d_pc_inc  = carry_flag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir         <= 8'h00;
            imm        <= 4'h0;
            sel        <= 2'b00;
            ld_a       <= 1'b0;
            ld_b       <= 1'b0;
            ld_out     <= 1'b0;
            pc_inc     <= 1'b0;
            pc_load    <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            case (cur)
                FETCH: begin
                    if (run) ir <= mem[pc];
                end
                DECODE: begin
                    imm     <= ir[3:0];
                    sel     <= d_sel;
                    ld_a    <= d_ld_a;
                    ld_b    <= d_ld_b;
                    ld_out  <= d_ld_out;
                    pc_inc  <= d_pc_inc;
                    pc_load <= d_pc_load;
                end
                EXEC: begin
                    ld_a    <= 1'b0;
                    ld_b    <= 1'b0;
                    ld_out  <= 1'b0;
                    pc_inc  <= 1'b0;
                    pc_load <= 1'b0;
                    if (is_add) carry_flag <= carry_in;
                end
                default: ;
            endcase
        end
    end

    // Program memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (prog_we && !run && cur == FETCH)
            mem[prog_addr] <= prog_data;
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboard bench for instruction_decoder: expected EXEC
// outputs are queued at issue and popped when EXEC appears.
module tb_instruction_decoder;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] imm;
        logic       ld_a;
        logic       ld_b;
        logic       ld_out;
        logic       pc_inc;
        logic       pc_load;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pc;
    logic       carry_in;
    logic       run;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [3:0] imm;
    logic [1:0] sel;
    logic       ld_a;
    logic       ld_b;
    logic       ld_out;
    logic       pc_inc;
    logic       pc_load;
    logic       carry_flag;
    logic [1:0] state;

    int   checks = 0;
    int   failures = 0;
    obs_t sb [$];

    instruction_decoder dut (
        .clk(clk), .rst(rst), .pc(pc), .carry_in(carry_in),
        .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .imm(imm), .sel(sel),
        .ld_a(ld_a), .ld_b(ld_b), .ld_out(ld_out),
        .pc_inc(pc_inc), .pc_load(pc_load),
        .carry_flag(carry_flag), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        run       = 1'b0;
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    // Issues one instruction at pc=p; n = cycles to reach EXEC, -1 on timeout.
    task automatic run_instr(input logic [3:0] p, input logic ci,
                             input logic drop, input obs_t e,
                             output obs_t o, output int n);
        sb.push_back(e);
        pc       = p;
        run      = 1'b1;
        carry_in = 1'b0;
        n        = 0;
        o        = '0;
        while (state != 2'b10 && n < 6) begin
            tick();
            n++;
            if (drop && state == 2'b01) run = 1'b0;
        end
        if (state == 2'b10) begin
            o = {sel, imm, ld_a, ld_b, ld_out, pc_inc, pc_load};
            carry_in = ci;
        end else begin
            n = -1;
        end
        tick();
        carry_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({state, imm, sel, ld_a, ld_b, ld_out, pc_inc, pc_load,
             carry_flag} !== 14'h0) begin
            failures++;
            $display("FAIL reset_vals got=%h exp=0", {state, imm, sel,
                     ld_a, ld_b, ld_out, pc_inc, pc_load, carry_flag});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_seq();
        obs_t o, e;
        int   n;
        load(4'd0, 8'h35);
        load(4'd1, 8'h90);
        run_instr(4'd0, 1'b0, 1'b0, '{2'b11, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}, o, n);
        e = sb.pop_front();
        checks++;
        if (n < 0 || o !== e) begin
            failures++;
            $display("FAIL mov_a5 got=%h exp=%h n=%0d", o, e, n);
        end
        checks++;
        if (n != 2 || state !== 2'b00) begin
            failures++;
            $display("FAIL seq_len got=%0d/%0d exp=2/0", n, state);
        end
        run_instr(4'd1, 1'b0, 1'b0, '{2'b01, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}, o, n);
        e = sb.pop_front();
        checks++;
        if (n < 0 || o !== e) begin
            failures++;
            $display("FAIL out_b got=%h exp=%h n=%0d", o, e, n);
        end
    endtask

    task automatic test_jmp();
        obs_t o, e;
        int   n;
        load(4'd2, 8'hF7);
        run_instr(4'd2, 1'b0, 1'b0, '{2'b11, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, o, n);
        e = sb.pop_front();
        checks++;
        if (n < 0 || o !== e) begin
            failures++;
            $display("FAIL jmp got=%h exp=%h n=%0d", o, e, n);
        end
    endtask

    task automatic test_carry_jnc();
        obs_t o, e;
        int   n;
        load(4'd3, 8'h0F);
        load(4'd4, 8'hE3);
        load(4'd5, 8'h52);
        run_instr(4'd3, 1'b1, 1'b0, '{2'b00, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}, o, n);
        e = sb.pop_front();
        checks++;
        if (n < 0 || o !== e) begin
            failures++;
            $display("FAIL add_a got=%h exp=%h", o, e);
        end
        checks++;
        if (carry_flag !== 1'b1) begin
            failures++;
            $display("FAIL carry_set got=%b exp=1", carry_flag);
        end
        run_instr(4'd4, 1'b0, 1'b0, '{2'b11, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, o, n);
        e = sb.pop_front();
        checks++;
        if (n < 0 || o !== e) begin
            failures++;
            $display("FAIL jnc_nt got=%h exp=%h", o, e);
        end
        checks++;
        if (carry_flag !== 1'b1) begin
            failures++;
            $display("FAIL carry_hold got=%b exp=1", carry_flag);
        end
        run_instr(4'd5, 1'b0, 1'b0, '{2'b01, 4'h2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, o, n);
        e = sb.pop_front();
        checks++;
        if (n < 0 || o !== e) begin
            failures++;
            $display("FAIL add_b got=%h exp=%h", o, e);
        end
        checks++;
        if (carry_flag !== 1'b0) begin
            failures++;
            $display("FAIL carry_clr got=%b exp=0", carry_flag);
        end
        run_instr(4'd4, 1'b0, 1'b0, '{2'b11, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, o, n);
        e = sb.pop_front();
        checks++;
        if (n < 0 || o !== e) begin
            failures++;
            $display("FAIL jnc_t got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_prog_guard_nop();
        obs_t o, e;
        int   n;
        load(4'd6, 8'h8A);
        prog_we   = 1'b1;
        prog_addr = 4'd6;
        prog_data = 8'h35;
        run_instr(4'd6, 1'b1, 1'b0, '{2'b11, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, o, n);
        e = sb.pop_front();
        checks++;
        if (n < 0 || o !== e) begin
            failures++;
            $display("FAIL nop got=%h exp=%h", o, e);
        end
        checks++;
        if (carry_flag !== 1'b0) begin
            failures++;
            $display("FAIL nop_carry got=%b exp=0", carry_flag);
        end
        run_instr(4'd6, 1'b0, 1'b0, '{2'b11, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, o, n);
        prog_we = 1'b0;
        run_instr(4'd6, 1'b0, 1'b0, '{2'b11, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, o, n);
        e = sb.pop_front();
        checks++;
        if (n < 0 || o !== e) begin
            failures++;
            $display("FAIL we_guard1 got=%h exp=%h", o, e);
        end
        e = sb.pop_front();
        checks++;
        if (n < 0 || o !== e) begin
            failures++;
            $display("FAIL we_guard2 got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_run_drop();
        obs_t o, e;
        int   n;
        run_instr(4'd0, 1'b0, 1'b1, '{2'b11, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}, o, n);
        e = sb.pop_front();
        checks++;
        if (n < 0 || o !== e) begin
            failures++;
            $display("FAIL drop_exec got=%h exp=%h", o, e);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({state, ld_a, ld_b, ld_out, pc_inc, pc_load} !== 7'h0) begin
                failures++;
                $display("FAIL park%0d got=%h exp=0", i,
                         {state, ld_a, ld_b, ld_out, pc_inc, pc_load});
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        obs_t o, e;
        int   n;
        run_instr(4'd3, 1'b1, 1'b0, '{2'b00, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}, o, n);
        e = sb.pop_front();
        checks++;
        if (n < 0 || o !== e || carry_flag !== 1'b1) begin
            failures++;
            $display("FAIL pre_rst got=%h/%b exp=%h/1", o, carry_flag, e);
        end
        pc = 4'd3;
        tick();
        tick();
        checks++;
        if (state !== 2'b10 || ld_a !== 1'b1) begin
            failures++;
            $display("FAIL rst_setup got=%0d/%b exp=2/1", state, ld_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({state, imm, ld_a, ld_b, ld_out, pc_inc, pc_load,
             carry_flag} !== 12'h0) begin
            failures++;
            $display("FAIL rst_async got=%h exp=0", {state, imm, ld_a,
                     ld_b, ld_out, pc_inc, pc_load, carry_flag});
        end
        run = 1'b0;
        #3 rst = 1'b0;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        pc        = 4'd0;
        carry_in  = 1'b0;
        run       = 1'b0;
        prog_we   = 1'b0;
        prog_addr = 4'd0;
        prog_data = 8'h00;
        test_reset();
        test_load_seq();
        test_jmp();
        test_carry_jnc();
        test_prog_guard_nop();
        test_run_drop();
        test_reset_mid_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

Fetch/decode stage that sits directly downstream of the 4-bit program counter. It holds the 16-word × 8-bit program memory, reads the word addressed by the current PC into an instruction register, and decodes it. It then issues one-cycle register-write, source-select and PC advance/jump strobes that the register file, ALU and program counter consume. It also keeps the carry flag used by conditional jumps.

## Interface
- No parameters; widths fixed (4-bit address/data path, 8-bit instruction).
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- pc  in  4  current program-counter value (program counter output)
- carry_in  in  1  ALU carry-out, valid during EXEC
- run  in  1  1 = execute program, 0 = hold in FETCH (program-load mode)
- prog_we  in  1  program-memory write strobe (honoured only while run=0)
- prog_addr  in  4  program-memory write address
- prog_data  in  8  program-memory write data
- imm  out  4  immediate field of current instruction
- sel  out  2  ALU source select: 00 reg A, 01 reg B, 10 input port, 11 zero
- ld_a, ld_b, ld_out  out  1 each  one-cycle write strobes
- pc_inc  out  1  one-cycle strobe: program counter advances by 1
- pc_load  out  1  one-cycle strobe: program counter loads imm
- carry_flag  out  1  stored carry flag
- state  out  2  FSM state (00 FETCH, 01 DECODE, 10 EXEC), for debug

## Operation
- Instruction word: [7:4] opcode, [3:0] immediate.
- FSM states: FETCH → DECODE → EXEC → FETCH. Every instruction takes 3 cycles.
- FETCH: if run=1, go to DECODE and latch ir <= mem[pc]. If run=0, stay in FETCH.
- DECODE: decode ir and register imm, sel and the strobe set. Go to EXEC.
- EXEC: strobes are valid for exactly this cycle. Go to FETCH.
- Opcode decode (sel / write strobe):
  - 0000 ADD A,Im: sel=00, ld_a
  - 0101 ADD B,Im: sel=01, ld_b
  - 0011 MOV A,Im: sel=11, ld_a
  - 0111 MOV B,Im: sel=11, ld_b
  - 0001 MOV A,B: sel=01, ld_a
  - 0100 MOV B,A: sel=00, ld_b
  - 0010 IN A: sel=10, ld_a
  - 0110 IN B: sel=10, ld_b
  - 1001 OUT B: sel=01, ld_out
  - 1011 OUT Im: sel=11, ld_out
  - 1111 JMP Im: sel=11, pc_load
  - 1110 JNC Im: sel=11, pc_load if carry_flag=0, else pc_inc
  - All other opcodes: NOP, no write strobe, sel=11
- Every non-jump instruction and every not-taken JNC asserts pc_inc. pc_inc and pc_load are never asserted together.
- Carry flag:
  - Updated only on the EXEC→FETCH edge of ADD A or ADD B, with carry_flag <= carry_in.
  - All other instructions leave it unchanged.
  - JNC tests the flag value held during its own DECODE.
- Program memory:
  - Written on a rising edge when prog_we=1 and run=0 and state=FETCH; otherwise the write is ignored.
  - A fetch reads the memory contents as of that edge. A write at the same address on the same edge is not seen by that fetch.
  - Memory contents are not affected by reset and are undefined at power-up.
- imm output carries ir[3:0] registered in DECODE and holds until the next DECODE.

## Timing
- Reset values: state=FETCH, ir=8'h00, imm=0, sel=00, ld_a/ld_b/ld_out/pc_inc/pc_load=0, carry_flag=0.
- Reset asserted in any state, including mid-EXEC: all strobes drop immediately and asynchronously; the program counter sees no advance.
- First fetch occurs on the first rising edge after rst deasserts with run=1.
- Latency:
  - pc sampled at edge N.
  - Strobes valid in the cycle after edge N+1, through edge N+2.
  - Program counter updates at edge N+2.
  - The next fetch samples the new pc at edge N+3.
- run is sampled only in FETCH. Dropping run in DECODE or EXEC does not abort the instruction; the FSM parks in the next FETCH.
- Strobes are 0 in FETCH and DECODE.

## Test plan
- Reset: assert rst mid-EXEC of ADD A → strobes 0 in the same cycle, state=00, carry_flag=0, imm=0.
- Load and sequencing:
  - Load mem[0]=8'h35 (MOV A,5), mem[1]=8'h9_0 (OUT B) with run=0.
  - Set run=1, driving pc=0 then pc=1 from a bench counter.
  - Required: EXEC cycle 1 shows sel=11, imm=5, ld_a=1, pc_inc=1; EXEC cycle 2 shows sel=01, ld_out=1, pc_inc=1.
  - Each instruction spans exactly 3 cycles.
- JMP: mem[2]=8'hF7 at pc=2 → EXEC shows pc_load=1, pc_inc=0, imm=7.
- Carry/JNC:
  - ADD A,Im (8'h0F) with carry_in=1 in EXEC → carry_flag=1.
  - Then JNC 3 (8'hE3) → pc_inc=1, pc_load=0.
  - Then ADD with carry_in=0, then JNC 3 → pc_load=1, imm=3.
- Run/program-load:
  - Drop run during DECODE → EXEC completes normally, then the FSM stays in FETCH with no strobes.
  - prog_we while run=1 → memory unchanged, confirmed by a later fetch.
- Undefined opcode: 8'h8A → no ld_* strobe, pc_inc=1, carry_flag unchanged.
